// File: rtl/gates_stim_sequencer.sv
// Operand generator for the two-input gates block.
// Manual mode passes two debounced switches through to a/b; auto mode sweeps
// the truth table 00,01,10,11 with a fixed dwell per vector, and flags each new
// vector with a one-cycle vec_valid strobe plus a done pulse at sweep end.
module gates_stim_sequencer #(
    parameter int DWELL      = 50,
    parameter int DEB_CYCLES = 4,
    parameter int CNT_W      = 8
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       mode,
    input  logic       start,
    input  logic       sw_a,
    input  logic       sw_b,
    output logic       a,
    output logic       b,
    output logic [1:0] vec_idx,
    output logic       vec_valid,
    output logic       busy,
    output logic       done
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SWEEP = 2'd1,
        DONE  = 2'd2
    } state_t;

    localparam logic [CNT_W-1:0] DEB_LAST   = CNT_W'(DEB_CYCLES - 1);
    localparam logic [CNT_W-1:0] DWELL_LAST = CNT_W'(DWELL - 1);

    // Bit 1 carries operand a, bit 0 carries operand b throughout.
    logic [1:0]       sw;
    logic [1:0]       sync_p0;
    logic [1:0]       sync_p1;
    logic [1:0]       stable;
    logic [1:0]       deb_hit;
    logic [1:0]       deb;
    logic [CNT_W-1:0] deb_cnt [2];

    state_t           state;
    state_t           state_next;
    logic [1:0]       ab;
    logic [1:0]       ab_next;
    logic [CNT_W-1:0] dwell;
    logic [CNT_W-1:0] dwell_next;
    logic             busy_next;
    logic             done_next;
    logic             force_vv;
    logic             vv_next;

    assign sw      = {sw_a, sw_b};
    assign a       = ab[1];
    assign b       = ab[0];
    assign vec_idx = ab;

    // Debounced value seen by the FSM: the stable value, already flipped in
    // the cycle whose edge will commit the toggle, so the output register
    // picks up the change on that same edge.
    always_comb begin
        deb_hit = '0;
        deb     = '0;
        for (int i = 0; i < 2; i++) begin
            deb_hit[i] = (sync_p1[i] != stable[i]) && (deb_cnt[i] == DEB_LAST);
            deb[i]     = stable[i] ^ deb_hit[i];
        end
    end

    // Two-flop synchronizers and per-input debounce counters; run in every state.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_p0 <= '0;
            sync_p1 <= '0;
            stable  <= '0;
            for (int i = 0; i < 2; i++) begin
                deb_cnt[i] <= '0;
            end
        end else begin
            sync_p0 <= sw;
            sync_p1 <= sync_p0;
            for (int i = 0; i < 2; i++) begin
                if (sync_p1[i] != stable[i]) begin
                    if (deb_hit[i]) begin
                        stable[i]  <= ~stable[i];
                        deb_cnt[i] <= '0;
                    end else begin
                        deb_cnt[i] <= deb_cnt[i] + CNT_W'(1);
                    end
                end else begin
                    deb_cnt[i] <= '0;
                end
            end
        end
    end

    // Next-state and next-output decode for the sequencer.
    always_comb begin
        state_next = state;
        ab_next    = ab;
        dwell_next = dwell;
        busy_next  = busy;
        done_next  = 1'b0;
        force_vv   = 1'b0;
        unique case (state)
            IDLE: begin
                if (mode) begin
                    if (start) begin
                        state_next = SWEEP;
                        ab_next    = 2'b00;
                        dwell_next = '0;
                        busy_next  = 1'b1;
                        force_vv   = 1'b1;
                    end
                end else begin
                    ab_next = deb;
                end
            end
            SWEEP: begin
                if (dwell == DWELL_LAST) begin
                    dwell_next = '0;
                    if (ab == 2'b11) begin
                        state_next = DONE;
                        done_next  = 1'b1;
                    end else begin
                        ab_next = ab + 2'd1;
                    end
                end else begin
                    dwell_next = dwell + CNT_W'(1);
                end
            end
            DONE: begin
                state_next = IDLE;
                busy_next  = 1'b0;
            end
            default: begin
                state_next = IDLE;
                busy_next  = 1'b0;
            end
        endcase
        // Vector 0 of a sweep is always announced, even if a/b were already 00.
        vv_next = force_vv || (ab_next != ab);
    end

    // State, operand and strobe registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            ab        <= 2'b00;
            dwell     <= '0;
            busy      <= 1'b0;
            done      <= 1'b0;
            vec_valid <= 1'b0;
        end else begin
            state     <= state_next;
            ab        <= ab_next;
            dwell     <= dwell_next;
            busy      <= busy_next;
            done      <= done_next;
            vec_valid <= vv_next;
        end
    end

endmodule

// File: tb/tb_gates_stim_sequencer.sv
// Directed bench for gates_stim_sequencer: reset, manual debounce and glitch
// rejection, simultaneous switches, auto sweeps with ignored restart and
// mid-sweep mode change, and asynchronous reset in the middle of a sweep.
module tb_gates_stim_sequencer;

    localparam int D = 50;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       mode;
    logic       start;
    logic       sw_a;
    logic       sw_b;
    logic       a;
    logic       b;
    logic [1:0] vec_idx;
    logic       vec_valid;
    logic       busy;
    logic       done;

    int errs   = 0;
    int checks = 0;
    int vv_seen;

    gates_stim_sequencer #(
        .DWELL      (D),
        .DEB_CYCLES (4),
        .CNT_W      (8)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .mode      (mode),
        .start     (start),
        .sw_a      (sw_a),
        .sw_b      (sw_b),
        .a         (a),
        .b         (b),
        .vec_idx   (vec_idx),
        .vec_valid (vec_valid),
        .busy      (busy),
        .done      (done)
    );

    // 10 ns clock
    always #5 clk = ~clk;

    task automatic chk(input string tag, input int obs, input int exp);
        checks++;
        if (obs != exp) begin
            errs++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Advance to just after the next rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Full auto sweep starting from IDLE; mode must be 1 on entry.
    // restart_at / mode_drop_at name the edge offset from T (0 = unused).
    task automatic run_sweep(input int restart_at, input int mode_drop_at, input string tag);
        int vv_cnt;
        int done_cnt;
        start = 1'b1;
        tick();
        start = 1'b0;
        chk({tag, "_entry_vv"}, int'(vec_valid), 1);
        chk({tag, "_entry_ab"}, int'({a, b}), 0);
        chk({tag, "_entry_busy"}, int'(busy), 1);
        vv_cnt   = 1;
        done_cnt = 0;
        for (int n = 1; n <= 4 * D + 1; n++) begin
            start = (n == restart_at);
            if (n == mode_drop_at) mode = 1'b0;
            tick();
            if (vec_valid) vv_cnt++;
            if (done) done_cnt++;
            if ((n % D == D - 1) && (n < 4 * D)) begin
                chk({tag, "_hold_ab"}, int'({a, b}), n / D);
            end
            if ((n % D == 0) && (n < 4 * D)) begin
                chk({tag, "_vec_ab"}, int'({a, b}), n / D);
                chk({tag, "_vec_idx"}, int'(vec_idx), n / D);
                chk({tag, "_vec_vv"}, int'(vec_valid), 1);
            end
            if (n == 4 * D) begin
                chk({tag, "_done"}, int'(done), 1);
                chk({tag, "_busy_in_done"}, int'(busy), 1);
                chk({tag, "_ab_in_done"}, int'({a, b}), 3);
            end
            if (n == 4 * D + 1) begin
                chk({tag, "_busy_exit"}, int'(busy), 0);
                chk({tag, "_done_exit"}, int'(done), 0);
            end
        end
        start = 1'b0;
        chk({tag, "_vv_count"}, vv_cnt, 4);
        chk({tag, "_done_count"}, done_cnt, 1);
    endtask

    initial begin
        rst_n = 1'b0;
        mode  = 1'b0;
        start = 1'b0;
        sw_a  = 1'b0;
        sw_b  = 1'b0;
        repeat (3) tick();
        chk("rst_a", int'(a), 0);
        chk("rst_b", int'(b), 0);
        chk("rst_idx", int'(vec_idx), 0);
        chk("rst_vv", int'(vec_valid), 0);
        chk("rst_busy", int'(busy), 0);
        chk("rst_done", int'(done), 0);

        rst_n = 1'b1;
        repeat (4) tick();
        chk("man_idle_ab", int'({a, b}), 0);
        chk("man_idle_vv", int'(vec_valid), 0);

        // sw_a rises before E1; a must appear at E6
        sw_a = 1'b1;
        repeat (5) tick();
        chk("deb_a_early", int'(a), 0);
        tick();
        chk("deb_a_rise", int'(a), 1);
        chk("deb_a_vv", int'(vec_valid), 1);
        chk("deb_a_idx", int'(vec_idx), 2);
        tick();
        chk("deb_a_vv_end", int'(vec_valid), 0);

        // 3-cycle glitch on sw_b is rejected
        vv_seen = 0;
        sw_b = 1'b1;
        repeat (3) begin
            tick();
            vv_seen |= int'(vec_valid);
        end
        sw_b = 1'b0;
        repeat (10) begin
            tick();
            vv_seen |= int'(vec_valid);
        end
        chk("glitch_b", int'(b), 0);
        chk("glitch_vv", vv_seen, 0);

        // both switches change together: 10 -> 01 on one edge
        sw_a = 1'b0;
        sw_b = 1'b1;
        repeat (5) tick();
        chk("sim_early", int'({a, b}), 2);
        tick();
        chk("sim_ab", int'({a, b}), 1);
        chk("sim_idx", int'(vec_idx), 1);
        chk("sim_vv", int'(vec_valid), 1);
        tick();
        chk("sim_vv_end", int'(vec_valid), 0);

        // sweep 1: restart pulse at T+60 must be ignored
        mode = 1'b1;
        run_sweep(60, 0, "sw1");
        tick();
        chk("sw1_post_ab", int'({a, b}), 3);
        chk("sw1_post_vv", int'(vec_valid), 0);
        chk("sw1_post_busy", int'(busy), 0);

        // sweep 2: switches move during the sweep, mode drops at T+30
        sw_a = 1'b1;
        sw_b = 1'b0;
        run_sweep(0, 30, "sw2");
        tick();
        chk("sw2_post_ab", int'({a, b}), 2);
        chk("sw2_post_idx", int'(vec_idx), 2);
        chk("sw2_post_vv", int'(vec_valid), 1);

        // sweep 3: asynchronous reset right after vector 2 is applied
        mode  = 1'b1;
        start = 1'b1;
        tick();
        start = 1'b0;
        repeat (100) tick();
        chk("sw3_vec2_ab", int'({a, b}), 2);
        chk("sw3_vec2_vv", int'(vec_valid), 1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("arst_a", int'(a), 0);
        chk("arst_b", int'(b), 0);
        chk("arst_idx", int'(vec_idx), 0);
        chk("arst_vv", int'(vec_valid), 0);
        chk("arst_busy", int'(busy), 0);
        chk("arst_done", int'(done), 0);
        tick();
        rst_n = 1'b1;
        repeat (3) tick();
        chk("arst_idle_ab", int'({a, b}), 0);
        chk("arst_idle_busy", int'(busy), 0);
        chk("arst_idle_vv", int'(vec_valid), 0);

        // sweep 4 from a/b = 00: entry pulse is forced
        run_sweep(0, 0, "sw4");

        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end

endmodule
